match_ctrl: RTL and testbench

Multi-cycle sequencer for the EX-stage byte-match operation (op_match). It latches an 8-bit pattern and a 32-bit subject on a start pulse, then scans the 25 byte-wide windows subject[i+7:i], i=0..24, STEP windows per cycle. It exits early on the first hit and returns the result to the ALU result mux. While scanning it raises a stall request to the pipeline control, and it honours flush.

---
 rtl/match_ctrl.sv | 124 ++++++++++++
 tb/tb_match_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/match_ctrl.sv
// match_ctrl: multi-cycle sequencer for the EX-stage byte-match operation.
// Latches an 8-bit pattern and a 32-bit subject, then scans the 25 bit-aligned
// byte windows subj[i+7:i] (i = 0..24), STEP windows per cycle, stopping on
// the first hit.
// Optional build macro MATCH_THERMO_EN: result becomes a thermometer mask
// instead of a hit index.
//
// Handshake: a start is accepted only in IDLE with flush low. stallreq holds
// the pipeline from the accepting cycle through the last SCAN cycle. done is
// a one-cycle pulse in DONE, and result is valid from that cycle until the
// next accepted start. flush returns the sequencer to IDLE with no done pulse.
module match_ctrl #(
  parameter int unsigned STEP     = 1,
  parameter logic [31:0] NO_MATCH = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        stallreq,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  pat;
  logic [31:0] subj;
  logic [4:0]  base;

  logic        accept;
  logic        hit;
  logic [4:0]  hit_idx;
  logic        last;
  logic [6:0]  win_idx;
  logic [31:0] shifted;
  logic [31:0] hit_value;
  logic [31:0] miss_value;

  assign accept    = (state == IDLE) && start && !flush;
  assign stallreq  = accept || (state == SCAN);
  assign busy      = (state == SCAN);
  // A flush landing in the DONE cycle kills the pulse as well.
  assign done      = (state == DONE) && !flush;
  assign dbg_state = state;

  // Compare this cycle's STEP windows; keep the lowest-index hit.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    win_idx = '0;
    shifted = '0;
    for (int j = 0; j < STEP; j++) begin
      win_idx = 7'(base) + 7'(j);
      shifted = subj >> win_idx;
      if (!hit && (win_idx <= 7'd24) && (shifted[7:0] == pat)) begin
        hit     = 1'b1;
        hit_idx = win_idx[4:0];
      end
    end
  end

  // This is the final SCAN cycle when the next base would pass window 24.
  assign last = (7'(base) + 7'(STEP)) > 7'd24;

`ifdef MATCH_THERMO_EN
  assign hit_value  = (32'd1 << hit_idx) - 32'd1;
  assign miss_value = 32'h01FF_FFFF;
`else
  assign hit_value  = {27'b0, hit_idx};
  assign miss_value = NO_MATCH;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = SCAN;
      SCAN: begin
        if (flush)            state_next = IDLE;
        else if (hit || last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, scan position and result register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pat    <= '0;
      subj   <= '0;
      base   <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        pat  <= src1[7:0];
        subj <= src2;
        base <= '0;
      end else if ((state == SCAN) && !flush) begin
        if (hit)       result <= hit_value;
        else if (last) result <= miss_value;
        else           base   <= base + 5'(STEP);
      end
    end
  end

endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: directed bench for match_ctrl. Two instances run side by
// side on the same inputs, one with STEP=1 and one with STEP=4, so each
// vector checks both latency profiles. Build with MATCH_THERMO_EN to check
// the thermometer result encoding.
module tb_match_ctrl;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;

  logic        stallreq1, busy1, done1;
  logic [31:0] result1;
  logic [1:0]  dbg1;
  logic        stallreq4, busy4, done4;
  logic [31:0] result4;
  logic [1:0]  dbg4;

  int n_checks = 0;
  int n_fail   = 0;

  match_ctrl #(.STEP(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .start(start), .src1(src1), .src2(src2),
    .flush(flush), .stallreq(stallreq1), .busy(busy1), .done(done1),
    .result(result1), .dbg_state(dbg1)
  );

  match_ctrl #(.STEP(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .start(start), .src1(src1), .src2(src2),
    .flush(flush), .stallreq(stallreq4), .busy(busy4), .done(done4),
    .result(result4), .dbg_state(dbg4)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] src1;
    logic [31:0] src2;
    int          lat1;
    int          lat4;
    logic [31:0] res_idx;
    logic [31:0] res_thermo;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] pick(input logic [31:0] idx_v, input logic [31:0] thermo_v);
`ifdef MATCH_THERMO_EN
    return thermo_v;
`else
    return idx_v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start; operand pins are scrambled afterwards.
  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    src1  = a;
    src2  = b;
    @(negedge clk);
    check({name, " stallreq1@T"}, 32'(stallreq1), 32'd1);
    check({name, " stallreq4@T"}, 32'(stallreq4), 32'd1);
    tick();
    start = 1'b0;
    src1  = $urandom_range(0, 32'hFFFF_FFFF);
    src2  = $urandom_range(0, 32'hFFFF_FFFF);
  endtask

  // Watch both instances up to cycle T+30; check latency, pulse count,
  // stallreq span, result at done, and result held afterwards.
  task automatic wait_check(input string name, input int first, input int lat1, input int lat4,
                            input logic [31:0] r1e, input logic [31:0] r4e);
    int c1 = 0, c4 = 0, n1 = 0, n4 = 0, s1 = 0, s4 = 0;
    logic [31:0] r1 = '0, r4 = '0;
    logic sd1 = 1'b0, sd4 = 1'b0;
    for (int cyc = first; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (done1) begin
        n1++;
        if (c1 == 0) begin c1 = cyc; r1 = result1; sd1 = stallreq1 | busy1; end
      end else if (c1 == 0 && stallreq1) s1++;
      if (done4) begin
        n4++;
        if (c4 == 0) begin c4 = cyc; r4 = result4; sd4 = stallreq4 | busy4; end
      end else if (c4 == 0 && stallreq4) s4++;
    end
    check({name, " lat1"}, 32'(c1), 32'(lat1));
    check({name, " pulses1"}, 32'(n1), 32'd1);
    check({name, " result1"}, r1, r1e);
    check({name, " stall1"}, 32'(s1), 32'(lat1 - first));
    check({name, " stall_at_done1"}, 32'(sd1), 32'd0);
    check({name, " held1"}, result1, r1e);
    check({name, " lat4"}, 32'(c4), 32'(lat4));
    check({name, " pulses4"}, 32'(n4), 32'd1);
    check({name, " result4"}, r4, r4e);
    check({name, " stall4"}, 32'(s4), 32'(lat4 - first));
    check({name, " held4"}, result4, r4e);
    tick();
  endtask

  task automatic check_quiet(input string name);
    check({name, " busy1"}, 32'(busy1), 32'd0);
    check({name, " done1"}, 32'(done1), 32'd0);
    check({name, " stall1"}, 32'(stallreq1), 32'd0);
    check({name, " state1"}, 32'(dbg1), 32'd0);
    check({name, " busy4"}, 32'(busy4), 32'd0);
    check({name, " done4"}, 32'(done4), 32'd0);
    check({name, " state4"}, 32'(dbg4), 32'd0);
  endtask

  initial begin
    logic [31:0] held1;
    logic [31:0] held4;
    int          extra;

    // src1, src2, lat STEP=1, lat STEP=4, index result, thermometer result
    vecs[0] = '{32'h0000_00AB, 32'h0000_00AB,  2, 2, 32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{32'h0000_0055, 32'hAAAA_AAAA,  3, 2, 32'h0000_0001, 32'h0000_0001};
    vecs[2] = '{32'h0000_00FF, 32'h1234_5678, 26, 8, 32'hFFFF_FFFF, 32'h01FF_FFFF};
    vecs[3] = '{32'h0000_00CD, 32'h00CD_0000, 18, 6, 32'h0000_0010, 32'h0000_FFFF};
    vecs[4] = '{32'h0000_00A5, 32'hA500_0000, 26, 8, 32'h0000_0018, 32'h00FF_FFFF};
    vecs[5] = '{32'hFFFF_FF3C, 32'h0003_C000, 14, 5, 32'h0000_000C, 32'h0000_0FFF};

    resetn = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    src1   = '0;
    src2   = '0;
    repeat (3) tick();
    resetn = 1'b1;
    @(negedge clk);
    check_quiet("reset");
    check("reset result1", result1, 32'h0);
    check("reset result4", result4, 32'h0);
    tick();

    // Start together with flush in IDLE is ignored.
    start = 1'b1;
    flush = 1'b1;
    src1  = 32'hAB;
    src2  = 32'hAB;
    @(negedge clk);
    check("start_flush stall1", 32'(stallreq1), 32'd0);
    tick();
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check_quiet("start_flush after");
    tick();

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      issue(nm, vecs[i].src1, vecs[i].src2);
      wait_check(nm, 1, vecs[i].lat1, vecs[i].lat4,
                 pick(vecs[i].res_idx, vecs[i].res_thermo),
                 pick(vecs[i].res_idx, vecs[i].res_thermo));
    end

    // Flush at T+5 during a long scan, then reissue at T+6.
    held1 = result1;
    held4 = result4;
    extra = 0;
    issue("flush", 32'hFF, 32'h1234_5678);
    repeat (4) begin
      @(negedge clk);
      if (done1 || done4) extra++;
      tick();
    end
    flush = 1'b1;
    @(negedge clk);
    if (done1 || done4) extra++;
    tick();
    flush = 1'b0;
    check("flush no_done", 32'(extra), 32'd0);
    check_quiet("flush T+6");
    check("flush held1", result1, held1);
    check("flush held4", result4, held4);
    issue("reissue", 32'hAB, 32'hAB);
    wait_check("reissue", 1, 2, 2, 32'h0, 32'h0);

    // Start while busy at T+3 is ignored; original result is delivered.
    issue("busy_start", 32'hFF, 32'h1234_5678);
    tick();
    tick();
    start = 1'b1;
    src1  = 32'hAB;
    src2  = 32'hAB;
    @(negedge clk);
    check("busy_start busy1", 32'(busy1), 32'd1);
    tick();
    start = 1'b0;
    wait_check("busy_start", 4, 26, 8, pick(32'hFFFF_FFFF, 32'h01FF_FFFF),
               pick(32'hFFFF_FFFF, 32'h01FF_FFFF));

    // Reset at T+4 mid-scan: outputs clear at T+5, no done afterwards.
    issue("reset_mid", 32'hFF, 32'h1234_5678);
    repeat (3) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    check_quiet("reset_mid");
    check("reset_mid result1", result1, 32'h0);
    check("reset_mid result4", result4, 32'h0);
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done1 || done4) extra++;
    end
    check("reset_mid no_done", 32'(extra), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
